// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core: real-time clock/calendar (sec/min/hour/day/month/year)
// with leap-year handling and per-field editing driven by debounced pulses.
// Optional alarm: define RTC_CALENDAR_CORE_ALARM_EN to add alarm_hour/alarm_min
// registers (edited through edit_sel 6/7) and the alarm_hit pulse.
module rtc_calendar_core #(
    parameter int TICK_DIV = 32768,
    parameter int PRESC_W  = 16,
    parameter int YEAR_MAX = 99
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] edit_sel,
    input  logic       inc,
    input  logic       dec,
    input  logic       alarm_on,
    output logic [5:0] sec,
    output logic [5:0] minute,
    output logic [4:0] hour,
    output logic [4:0] day,
    output logic [3:0] month,
    output logic [6:0] year,
    output logic       sec_tick,
    output logic       alarm_hit
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [6:0]         YEAR_LAST  = 7'(YEAR_MAX);

    // Days in a month; February is 29 whenever the two low year bits are zero.
    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [6:0] y);
        logic [4:0] d;
        case (m)
            4'd2:                    d = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            default:                 d = 5'd31;
        endcase
        return d;
    endfunction

    // One step up or down inside [lo, hi], wrapping at both ends, no carry out.
    function automatic logic [6:0] wrap_step(input logic [6:0] v, input logic [6:0] lo,
                                             input logic [6:0] hi, input logic up);
        logic [6:0] r;
        if (up) r = (v >= hi) ? lo : v + 7'd1;
        else    r = (v <= lo) ? hi : v - 7'd1;
        return r;
    endfunction

    logic [PRESC_W-1:0] presc_reg, presc_next;
    logic [5:0]         sec_reg, sec_next;
    logic [5:0]         minute_reg, minute_next;
    logic [4:0]         hour_reg, hour_next;
    logic [4:0]         day_reg, day_next;
    logic [3:0]         month_reg, month_next;
    logic [6:0]         year_reg, year_next;
    logic               tick_reg, tick_next;
    logic               edit_mode;
    logic               step_any;
    logic               step_up;
    logic [4:0]         dim_cur;
    logic [4:0]         dim_edit;

`ifdef RTC_CALENDAR_CORE_ALARM_EN
    logic [4:0] alarm_hour_reg, alarm_hour_next;
    logic [5:0] alarm_min_reg, alarm_min_next;
    logic       hit_reg, hit_next;

    assign edit_mode = (edit_sel != 3'd0);
    assign alarm_hit = hit_reg;
`else
    // alarm_on has no function without the alarm option
    logic unused_alarm_on;
    assign unused_alarm_on = alarm_on;

    assign edit_mode = (edit_sel != 3'd0) && (edit_sel <= 3'd5);
    assign alarm_hit = 1'b0;
`endif

    // Simultaneous inc and dec cancel out.
    assign step_any = inc ^ dec;
    assign step_up  = inc;
    assign dim_cur  = days_in_month(month_reg, year_reg);

    // Next-state: running cascade on prescaler wrap, or in-field edits.
    always_comb begin
        presc_next  = presc_reg;
        sec_next    = sec_reg;
        minute_next = minute_reg;
        hour_next   = hour_reg;
        day_next    = day_reg;
        month_next  = month_reg;
        year_next   = year_reg;
        tick_next   = 1'b0;
        dim_edit    = dim_cur;
`ifdef RTC_CALENDAR_CORE_ALARM_EN
        alarm_hour_next = alarm_hour_reg;
        alarm_min_next  = alarm_min_reg;
        hit_next        = 1'b0;
`endif
        if (!edit_mode) begin
            if (presc_reg == PRESC_LAST) begin
                presc_next = '0;
                tick_next  = 1'b1;
                if (sec_reg != 6'd59) begin
                    sec_next = sec_reg + 6'd1;
                end else begin
                    sec_next = 6'd0;
                    if (minute_reg != 6'd59) begin
                        minute_next = minute_reg + 6'd1;
                    end else begin
                        minute_next = 6'd0;
                        if (hour_reg != 5'd23) begin
                            hour_next = hour_reg + 5'd1;
                        end else begin
                            hour_next = 5'd0;
                            if (day_reg < dim_cur) begin
                                day_next = day_reg + 5'd1;
                            end else begin
                                day_next = 5'd1;
                                if (month_reg != 4'd12) begin
                                    month_next = month_reg + 4'd1;
                                end else begin
                                    month_next = 4'd1;
                                    year_next  = (year_reg >= YEAR_LAST) ? 7'd0 : year_reg + 7'd1;
                                end
                            end
                        end
                    end
                end
`ifdef RTC_CALENDAR_CORE_ALARM_EN
                hit_next = alarm_on && (sec_next == 6'd0) && (minute_next == alarm_min_reg)
                           && (hour_next == alarm_hour_reg);
`endif
            end else begin
                presc_next = presc_reg + PRESC_W'(1);
            end
        end else begin
            // Editing freezes the seconds so the new time starts on a clean second.
            presc_next = '0;
            sec_next   = 6'd0;
            if (step_any) begin
                case (edit_sel)
                    3'd1: hour_next   = 5'(wrap_step(7'(hour_reg), 7'd0, 7'd23, step_up));
                    3'd2: minute_next = 6'(wrap_step(7'(minute_reg), 7'd0, 7'd59, step_up));
                    3'd3: begin
                        month_next = 4'(wrap_step(7'(month_reg), 7'd1, 7'd12, step_up));
                        dim_edit   = days_in_month(month_next, year_reg);
                        if (day_reg > dim_edit) day_next = dim_edit;
                    end
                    3'd4: day_next = 5'(wrap_step(7'(day_reg), 7'd1, 7'(dim_cur), step_up));
                    3'd5: begin
                        year_next = wrap_step(year_reg, 7'd0, YEAR_LAST, step_up);
                        dim_edit  = days_in_month(month_reg, year_next);
                        if (day_reg > dim_edit) day_next = dim_edit;
                    end
`ifdef RTC_CALENDAR_CORE_ALARM_EN
                    3'd6: alarm_hour_next = 5'(wrap_step(7'(alarm_hour_reg), 7'd0, 7'd23, step_up));
                    3'd7: alarm_min_next  = 6'(wrap_step(7'(alarm_min_reg), 7'd0, 7'd59, step_up));
`endif
                    default: ;
                endcase
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_reg  <= '0;
            sec_reg    <= 6'd0;
            minute_reg <= 6'd0;
            hour_reg   <= 5'd0;
            day_reg    <= 5'd1;
            month_reg  <= 4'd1;
            year_reg   <= 7'd0;
            tick_reg   <= 1'b0;
`ifdef RTC_CALENDAR_CORE_ALARM_EN
            alarm_hour_reg <= 5'd0;
            alarm_min_reg  <= 6'd0;
            hit_reg        <= 1'b0;
`endif
        end else begin
            presc_reg  <= presc_next;
            sec_reg    <= sec_next;
            minute_reg <= minute_next;
            hour_reg   <= hour_next;
            day_reg    <= day_next;
            month_reg  <= month_next;
            year_reg   <= year_next;
            tick_reg   <= tick_next;
`ifdef RTC_CALENDAR_CORE_ALARM_EN
            alarm_hour_reg <= alarm_hour_next;
            alarm_min_reg  <= alarm_min_next;
            hit_reg        <= hit_next;
`endif
        end
    end

    assign sec      = sec_reg;
    assign minute   = minute_reg;
    assign hour     = hour_reg;
    assign day      = day_reg;
    assign month    = month_reg;
    assign year     = year_reg;
    assign sec_tick = tick_reg;

endmodule
